// File: rtl/fault_cmp_pkg.sv
// Shared types and golden model for the fault-comparison monitor.
package fault_cmp_pkg;

  // Campaign phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cmp_state_e;

  localparam int unsigned DEF_VEC_W = 4;
  localparam int unsigned DEF_CNT_W = 16;

  // Mismatch record layout, MSB first. The FIFO carries the same bit layout
  // for any CNT_W/VEC_W: {idx, vec, faulty_y}.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] idx;
    logic [DEF_VEC_W-1:0] vec;
    logic                 faulty_y;
  } mm_rec_t;

  // Fault-free combinational DUT: y = (a|b) ^ (e|!f), v = {a,b,e,f}
  function automatic logic fault_cmp_golden(input logic [3:0] v);
    return (v[3] | v[2]) ^ (v[1] | ~v[0]);
  endfunction

endpackage

// File: rtl/fault_cmp_fifo.sv
// Show-ahead FIFO for mismatch records. Head word is visible while not empty;
// when empty the output holds the most recently popped word. A push into a
// full FIFO is accepted only if a pop happens on the same edge, otherwise it
// is dropped and o_drop flags it.
module fault_cmp_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);
  import fault_cmp_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fault_cmp_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW:0]                 r_wr;
  logic [AW:0]                 r_rd;
  logic [WIDTH-1:0]            r_last;
  logic                        w_pop;
  logic                        w_push;

  // Extra pointer bit distinguishes full from empty
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & o_full & ~w_pop;
  assign o_dout  = o_empty ? r_last : r_mem[r_rd[AW-1:0]];

  // Storage and pointer update; r_last keeps the popped word for hold-when-empty
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem  <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_last <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= i_din;
        r_wr                <= r_wr + PTR_ONE;
      end
      if (w_pop) begin
        r_last <= r_mem[r_rd[AW-1:0]];
        r_rd   <= r_rd + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/fault_cmp_monitor.sv
// Golden-vs-faulty comparison monitor. Counts samples and mismatches per
// campaign and streams one record per mismatch over a valid/ready port.
// Optional macro FAULT_CMP_SELF_GOLDEN_EN: compute the reference output
// internally from the applied vector instead of using the golden input.
module fault_cmp_monitor
  import fault_cmp_pkg::*;
#(
  parameter int VEC_W       = 4,
  parameter int CNT_W       = 16,
  parameter int NUM_VECTORS = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_smp_valid,
  input  logic [VEC_W-1:0] i_smp_vec,
  input  logic             i_golden_y,
  input  logic             i_faulty_y,
  output logic             o_rec_valid,
  input  logic             i_rec_ready,
  output logic [CNT_W-1:0] o_rec_idx,
  output logic [VEC_W-1:0] o_rec_vec,
  output logic             o_rec_faulty_y,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_vec_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_overflow,
  output logic             o_fault_detect
);

  localparam int              REC_W    = CNT_W + VEC_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VECTORS - 1);

  cmp_state_e       r_state;
  cmp_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_overflow;
  logic             w_golden;
  logic             w_mismatch;
  logic             w_take;
  logic             w_last;
  logic             w_start_run;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_drop;
  logic [REC_W-1:0] w_push_rec;
  logic [REC_W-1:0] w_head_rec;

`ifdef FAULT_CMP_SELF_GOLDEN_EN
  if (VEC_W != 4) begin : g_bad_vec_w
    $error("fault_cmp_monitor: self-golden reference requires VEC_W == 4");
  end
  assign w_golden = fault_cmp_golden(i_smp_vec[3:0]);
`else
  assign w_golden = i_golden_y;
`endif

  assign w_mismatch  = w_golden ^ i_faulty_y;
  assign w_take      = (r_state == RUN) && i_smp_valid;
  assign w_last      = (r_vec_cnt == CNT_LAST);
  assign w_start_run = ((r_state == IDLE) || (r_state == DONE)) && i_start;
  assign w_push      = w_take && w_mismatch;
  assign w_pop       = o_rec_valid && i_rec_ready;
  assign w_push_rec  = {r_vec_cnt, i_smp_vec, i_faulty_y};

  // Campaign sequencing and status flags
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (w_take && w_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (w_empty) w_state_nxt = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        if (i_start) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Per-campaign counters; cleared when a campaign starts, not on completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vec_cnt  <= '0;
      r_err_cnt  <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_run) begin
      r_vec_cnt  <= '0;
      r_err_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_take) r_vec_cnt <= r_vec_cnt + CNT_ONE;
      if (w_push && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_ONE;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  fault_cmp_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_din   (w_push_rec),
    .i_pop   (w_pop),
    .o_dout  (w_head_rec),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_drop  (w_drop)
  );

  assign o_rec_valid    = ~w_empty;
  assign o_rec_idx      = w_head_rec[REC_W-1 -: CNT_W];
  assign o_rec_vec      = w_head_rec[VEC_W:1];
  assign o_rec_faulty_y = w_head_rec[0];
  assign o_vec_cnt      = r_vec_cnt;
  assign o_err_cnt      = r_err_cnt;
  assign o_overflow     = r_overflow;
  assign o_fault_detect = (r_err_cnt != '0);

endmodule
